// File: rtl/display_mux_pkg.sv
// Shared definitions for the N-digit display multiplexer.
//   - idx_w      : width of a slot index for a given digit count (min 1 bit)
//   - en_level   : physical level of a digit enable given its polarity
//   - digit_t    : default-width digit value type
//   - lz_mask    : leading-zero display mask, used when the build defines
//                  DISPLAY_MUX_LZ_BLANK_EN
package display_mux_pkg;

  localparam int DEF_DIGIT_W = 4;
  typedef logic [DEF_DIGIT_W-1:0] digit_t;

  // Upper bounds for the leading-zero helper; the top checks its own
  // parameters against these when the feature is built in.
  localparam int LZ_MAX_DIGITS = 16;
  localparam int LZ_MAX_DW     = 8;
  localparam int LZ_W          = LZ_MAX_DIGITS * LZ_MAX_DW;
  localparam int LZ_IW         = $clog2(LZ_W);
  localparam int LZ_MW         = $clog2(LZ_MAX_DIGITS);

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // active=1 asks for the "on" level; active_low!=0 inverts the drive.
  function automatic logic en_level(input logic active, input int active_low);
    return active ^ (active_low != 0);
  endfunction

  // Bit i is 1 when digit i should be shown: digit 0 always, digit i>0
  // only if it or some higher digit is non-zero. d holds n digits of dw
  // bits each, packed from bit 0 upwards.
  function automatic logic [LZ_MAX_DIGITS-1:0] lz_mask(input logic [LZ_W-1:0] d,
                                                       input int n, input int dw);
    logic [LZ_MAX_DIGITS-1:0] m;
    logic seen;
    logic nz;
    m    = '0;
    seen = 1'b0;
    for (int i = LZ_MAX_DIGITS - 1; i >= 0; i--) begin
      nz = 1'b0;
      for (int b = 0; b < LZ_MAX_DW; b++) begin
        if (i < n && b < dw) nz = nz | d[LZ_IW'(i * dw + b)];
      end
      seen = seen | nz;
      m[LZ_MW'(i)] = (i < n) && (seen || i == 0);
    end
    return m;
  endfunction

endpackage

// File: rtl/display_mux_n_refresh_timer.sv
// refresh_timer: slot prescaler and slot index for the display multiplexer.
//   clk, reset : clock, asynchronous active-high reset
//   idx_nxt    : slot index the next cycle will belong to
//   win_nxt    : next cycle lies outside the blanking window
//   frame_end  : registered, high during the last cycle of each frame
// The *_nxt outputs let the top register its outputs so they line up with
// the current cnt/idx without a cycle of lag.
module refresh_timer
  import display_mux_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16,
  localparam int CNT_W = $clog2(REFRESH_DIV),
  localparam int IDX_W = idx_w(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             win_nxt,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] idx;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    idx_nxt = idx;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Blanking window: the first BLANK_CYCLES counts of each slot.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign win_nxt = 1'b1;
  end else begin : g_blank
    assign win_nxt = (cnt_nxt >= CNT_W'(BLANK_CYCLES));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= '0;
      frame_end <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      frame_end <= (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
    end
  end

endmodule

// File: rtl/display_mux_n.sv
// display_mux_n: time-multiplexes NUM_DIGITS digits onto one digit bus with
// per-slot blanking dead-time and frame-synchronous (tear-free) updates.
//   clk, reset : clock, asynchronous active-high reset
//   digits_in  : packed digit values, digit i at [i*DIGIT_W +: DIGIT_W]
//   mask_in    : per-digit show enable (1 = shown)
//   update     : single-cycle load request; no handshake, every asserted
//                cycle is taken and the last one before a commit wins
//   seg_digit  : value of the current slot's digit
//   digit_en   : digit drive enables, active-low when EN_ACTIVE_LOW=1
//   frame_end  : high in the last cycle of each frame
//   pending    : an update is staged but not yet committed
// Build option: define DISPLAY_MUX_LZ_BLANK_EN to suppress leading zeros
// (the mask committed with each update is further restricted so that
// high-order zero digits are not lit; digit 0 is always eligible).
module display_mux_n
  import display_mux_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int DIGIT_W       = 4,
  parameter int REFRESH_DIV   = 1000,
  parameter int BLANK_CYCLES  = 16,
  parameter int EN_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         mask_in,
  input  logic                          update,
  output logic [DIGIT_W-1:0]            seg_digit,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_end,
  output logic                          pending
);

  localparam int   IDX_W  = idx_w(NUM_DIGITS);
  localparam int   DATA_W = NUM_DIGITS * DIGIT_W;
  localparam logic EN_ON  = en_level(1'b1, EN_ACTIVE_LOW);
  localparam logic EN_OFF = en_level(1'b0, EN_ACTIVE_LOW);

  if (NUM_DIGITS < 2) begin : g_chk_n
    $error("display_mux_n: NUM_DIGITS must be >= 2");
  end
  if (REFRESH_DIV < 2) begin : g_chk_div
    $error("display_mux_n: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_chk_blank
    $error("display_mux_n: BLANK_CYCLES must be in 0..REFRESH_DIV-1");
  end

  logic [IDX_W-1:0]      idx_nxt;
  logic                  win_nxt;
  logic [DATA_W-1:0]     stg_d, shd_d, shd_d_nxt, d_src;
  logic [NUM_DIGITS-1:0] stg_m, shd_m, shd_m_nxt, m_src, eff_m;
  logic [DIGIT_W-1:0]    seg_nxt;
  logic [NUM_DIGITS-1:0] en_nxt;

  refresh_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .idx_nxt  (idx_nxt),
    .win_nxt  (win_nxt),
    .frame_end(frame_end)
  );

  // An update in the frame_end cycle bypasses staging straight to shadow.
  assign d_src = update ? digits_in : stg_d;
  assign m_src = update ? mask_in   : stg_m;

`ifdef DISPLAY_MUX_LZ_BLANK_EN
  if (NUM_DIGITS > LZ_MAX_DIGITS || DIGIT_W > LZ_MAX_DW) begin : g_chk_lz
    $error("display_mux_n: digit count/width too large for leading-zero blanking");
  end
  logic [LZ_MAX_DIGITS-1:0] lz_full;
  assign lz_full = lz_mask(LZ_W'(d_src), NUM_DIGITS, DIGIT_W);
  assign eff_m   = m_src & lz_full[NUM_DIGITS-1:0];
`else
  assign eff_m = m_src;
`endif

  always_comb begin
    shd_d_nxt = shd_d;
    shd_m_nxt = shd_m;
    if (frame_end && (update || pending)) begin
      shd_d_nxt = d_src;
      shd_m_nxt = eff_m;
    end
  end

  // Outputs are computed from next-cycle state and registered, so they
  // are flop-driven yet aligned to the slot they describe.
  always_comb begin
    seg_nxt = '0;
    en_nxt  = {NUM_DIGITS{EN_OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        seg_nxt = shd_d_nxt[i*DIGIT_W +: DIGIT_W];
        if (win_nxt && shd_m_nxt[i]) en_nxt[i] = EN_ON;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_d     <= '0;
      stg_m     <= '0;
      shd_d     <= '0;
      shd_m     <= '0;
      pending   <= 1'b0;
      seg_digit <= '0;
      digit_en  <= {NUM_DIGITS{EN_OFF}};
    end else begin
      if (update) begin
        stg_d <= digits_in;
        stg_m <= mask_in;
      end
      pending   <= frame_end ? 1'b0 : (update | pending);
      shd_d     <= shd_d_nxt;
      shd_m     <= shd_m_nxt;
      seg_digit <= seg_nxt;
      digit_en  <= en_nxt;
    end
  end

endmodule

// File: tb/tb_display_mux_n.sv
module tb_display_mux_n;

  localparam int N     = 2;
  localparam int DW    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;
  localparam int EW    = DW + N + 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] digits_in;
  logic [N-1:0]    mask_in;
  logic            update;
  logic [DW-1:0]   seg_digit;
  logic [N-1:0]    digit_en;
  logic            frame_end;
  logic            pending;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Scoreboard: {seg_digit, digit_en, frame_end, pending} per cycle.
  logic [EW-1:0] exp_q[$];

  // Reference model: what the display currently shows and what is staged.
  int            t;
  logic [DW-1:0] disp_d[N];
  logic [N-1:0]  disp_m;
  logic [N*DW-1:0] stg_d;
  logic [N-1:0]  stg_m;
  logic          pend;

  display_mux_n #(
    .NUM_DIGITS   (N),
    .DIGIT_W      (DW),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK),
    .EN_ACTIVE_LOW(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digits_in(digits_in),
    .mask_in  (mask_in),
    .update   (update),
    .seg_digit(seg_digit),
    .digit_en (digit_en),
    .frame_end(frame_end),
    .pending  (pending)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
  endtask

  function automatic logic [N-1:0] model_mask(input logic [N*DW-1:0] d, input logic [N-1:0] m);
    logic [N-1:0] r;
    r = m;
`ifdef DISPLAY_MUX_LZ_BLANK_EN
    for (int i = 1; i < N; i++) if ((d >> (i * DW)) == 0) r[i] = 1'b0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < N; i++) disp_d[i] = '0;
    disp_m = '0;
    stg_d  = '0;
    stg_m  = '0;
    pend   = 1'b0;
  endtask

  task automatic model_load(input logic [N*DW-1:0] d, input logic [N-1:0] m);
    for (int i = 0; i < N; i++) disp_d[i] = d[i*DW +: DW];
    disp_m = model_mask(d, m);
  endtask

  // Driver: called at posedge+1; drives one cycle and predicts its outputs.
  task automatic run_cycle(input logic upd, input logic [N*DW-1:0] d, input logic [N-1:0] m);
    int c;
    int s;
    logic fe;
    logic [N-1:0] en;
    update    = upd;
    digits_in = d;
    mask_in   = m;
    c  = t % DIV;
    s  = (t / DIV) % N;
    fe = (c == DIV - 1) && (s == N - 1);
    en = '1;
    if (c >= BLANK && disp_m[s]) en[s] = 1'b0;
    exp_q.push_back({disp_d[s], en, fe, pend});
    if (fe && upd) begin
      model_load(d, m);
      pend = 1'b0;
    end else if (fe && pend) begin
      model_load(stg_d, stg_m);
      pend = 1'b0;
    end
    if (upd) begin
      stg_d = d;
      stg_m = m;
      if (!fe) pend = 1'b1;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, '0);
  endtask

  task automatic idle_until(input int phase);
    while (t % FRAME != phase) run_cycle(1'b0, '0, '0);
  endtask

  // Monitor: compares every presented cycle against the scoreboard.
  logic [EW-1:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("outputs", {seg_digit, digit_en, frame_end, pending}, mon_exp);
        check_cnt++;
        if ($countones(~digit_en) <= 1) pass_cnt++;
        else $display("FAIL onehot t=%0d actual=%b required=at_most_one_active", t, digit_en);
      end
    end
  end

  // Stimulus
  initial begin
    reset     = 1'b1;
    update    = 1'b0;
    digits_in = '0;
    mask_in   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", {seg_digit, digit_en, frame_end, pending}, {4'h0, 2'b11, 1'b0, 1'b0});
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle frame after reset: nothing enabled, frame_end at cycle 15.
    idle(FRAME);

    // Staged update mid-frame, committed at the frame boundary.
    idle_until(3);
    run_cycle(1'b1, 8'hF2, 2'b11);
    idle(2 * FRAME);

    // Update in the frame_end cycle bypasses staging.
    idle_until(FRAME - 1);
    run_cycle(1'b1, 8'h39, 2'b11);
    idle(FRAME);

    // Two updates in one frame: last wins.
    idle_until(1);
    run_cycle(1'b1, 8'h11, 2'b11);
    idle(4);
    run_cycle(1'b1, 8'h44, 2'b11);
    idle(2 * FRAME);

    // Digit 1 masked off; then asynchronous reset in the middle of slot 1.
    idle_until(2);
    run_cycle(1'b1, 8'h7A, 2'b01);
    idle(FRAME);
    idle_until(DIV + 3);
    #1 reset = 1'b1;
    #1 check("async_reset", {seg_digit, digit_en, frame_end, pending}, {4'h0, 2'b11, 1'b0, 1'b0});
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(FRAME);

    // Leading-zero cases (behaviour depends on the build).
    idle_until(5);
    run_cycle(1'b1, 8'h05, 2'b11);
    idle(2 * FRAME);
    run_cycle(1'b1, 8'h00, 2'b11);
    idle(2 * FRAME);
    run_cycle(1'b1, 8'h50, 2'b11);
    idle(2 * FRAME);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      run_cycle($urandom_range(0, 5) == 0, 8'($urandom), 2'($urandom_range(0, 3)));
    end
    idle(FRAME);

    @(negedge clk);
    #1;
    check_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain actual=%0d required=0 leftover entries", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
